// File: rtl/des_job_arbiter_if.sv
// Bundle between des_job_arbiter (slave), its two requesters and the DES core (master side).
interface des_job_arbiter_if #(
    parameter int DW = 64
);
    logic          req0;
    logic          req1;
    logic          mode0;
    logic          mode1;
    logic [DW-1:0] text0;
    logic [DW-1:0] text1;
    logic [DW-1:0] key0;
    logic [DW-1:0] key1;
    logic          ack0;
    logic          ack1;
    logic          res_valid0;
    logic          res_valid1;
    logic [DW-1:0] res_data;
    logic          res_err;
    logic          busy;
    logic          core_start;
    logic          core_decrypt;
    logic [DW-1:0] core_text;
    logic [DW-1:0] core_key;
    logic          core_done;
    logic [DW-1:0] core_result;

    modport slave (
        input  req0, req1, mode0, mode1, text0, text1, key0, key1,
        input  core_done, core_result,
        output ack0, ack1, res_valid0, res_valid1, res_data, res_err, busy,
        output core_start, core_decrypt, core_text, core_key
    );

    modport master (
        output req0, req1, mode0, mode1, text0, text1, key0, key1,
        output core_done, core_result,
        input  ack0, ack1, res_valid0, res_valid1, res_data, res_err, busy,
        input  core_start, core_decrypt, core_text, core_key
    );
endinterface

// File: rtl/des_job_arbiter.sv
// Round-robin sharing of one DES core between two requesters, all outputs registered.
// Optional WAIT watchdog enabled by defining DES_WDOG_EN.
module des_job_arbiter #(
    parameter int DW      = 64,
    parameter int TIMEOUT = 32,
    parameter int CW      = 6
) (
    input  logic             clk,
    input  logic             rst,
    des_job_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          res_valid0_q, res_valid0_d;
    logic          res_valid1_q, res_valid1_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          res_err_q, res_err_d;
    logic          busy_q, busy_d;
    logic          core_start_q, core_start_d;
    logic          core_decrypt_q, core_decrypt_d;
    logic [DW-1:0] core_text_q, core_text_d;
    logic [DW-1:0] core_key_q, core_key_d;

    logic any_req;
    logic pick;
    logic timeout;

    if (TIMEOUT < 1 || TIMEOUT > (2**CW) - 1) begin : g_cw_check
        $error("des_job_arbiter: CW too narrow for TIMEOUT");
    end

    assign any_req = bus.req0 | bus.req1;
    // A tie goes to whoever was not served last; a lone request always wins.
    assign pick    = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

`ifdef DES_WDOG_EN
    logic [CW-1:0] wdog_q, wdog_d;

    // core_done takes priority, so the timeout only fires on a silent cycle.
    assign timeout = (state_q == S_WAIT) && (wdog_q == CW'(TIMEOUT)) && !bus.core_done;

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == S_START) begin
            wdog_d = '0;
        end else if (state_q == S_WAIT) begin
            wdog_d = wdog_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            grant_q        <= 1'b0;
            last_q         <= 1'b1;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            res_valid0_q   <= 1'b0;
            res_valid1_q   <= 1'b0;
            res_data_q     <= '0;
            res_err_q      <= 1'b0;
            busy_q         <= 1'b0;
            core_start_q   <= 1'b0;
            core_decrypt_q <= 1'b0;
            core_text_q    <= '0;
            core_key_q     <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_q         <= last_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            res_valid0_q   <= res_valid0_d;
            res_valid1_q   <= res_valid1_d;
            res_data_q     <= res_data_d;
            res_err_q      <= res_err_d;
            busy_q         <= busy_d;
            core_start_q   <= core_start_d;
            core_decrypt_q <= core_decrypt_d;
            core_text_q    <= core_text_d;
            core_key_q     <= core_key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (bus.core_done || timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d        = grant_q;
        last_d         = last_q;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        res_valid0_d   = 1'b0;
        res_valid1_d   = 1'b0;
        res_data_d     = res_data_q;
        res_err_d      = res_err_q;
        core_start_d   = 1'b0;
        core_decrypt_d = core_decrypt_q;
        core_text_d    = core_text_q;
        core_key_d     = core_key_q;
        // Registered, so it must look at where the FSM is heading.
        busy_d         = (state_d != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d        = pick;
                    ack0_d         = ~pick;
                    ack1_d         = pick;
                    core_start_d   = 1'b1;
                    core_decrypt_d = pick ? bus.mode1 : bus.mode0;
                    core_text_d    = pick ? bus.text1 : bus.text0;
                    core_key_d     = pick ? bus.key1  : bus.key0;
                end
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    res_data_d   = bus.core_result;
                    res_err_d    = 1'b0;
                    res_valid0_d = ~grant_q;
                    res_valid1_d = grant_q;
                end else if (timeout) begin
                    res_data_d   = '0;
                    res_err_d    = 1'b1;
                    res_valid0_d = ~grant_q;
                    res_valid1_d = grant_q;
                end
            end
            S_RESP: begin
                last_d = grant_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.ack0         = ack0_q;
    assign bus.ack1         = ack1_q;
    assign bus.res_valid0   = res_valid0_q;
    assign bus.res_valid1   = res_valid1_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_err      = res_err_q;
    assign bus.busy         = busy_q;
    assign bus.core_start   = core_start_q;
    assign bus.core_decrypt = core_decrypt_q;
    assign bus.core_text    = core_text_q;
    assign bus.core_key     = core_key_q;
endmodule

// File: tb/tb_des_job_arbiter.sv
// Randomized job-level bench for des_job_arbiter with a timeline/round-robin reference model.
// Define DES_WDOG_EN for both RTL and bench to exercise the watchdog.
module tb_des_job_arbiter;
    localparam int DW      = 64;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   job_no   = 0;
    bit   last_m   = 1'b1;

    always #5 clk = ~clk;

    des_job_arbiter_if #(.DW(DW)) bus_if ();

    des_job_arbiter #(
        .DW(DW),
        .TIMEOUT(TIMEOUT),
        .CW(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack0"}, bus_if.ack0, 0);
        check_eq({tag, "_ack1"}, bus_if.ack1, 0);
        check_eq({tag, "_rv0"}, bus_if.res_valid0, 0);
        check_eq({tag, "_rv1"}, bus_if.res_valid1, 0);
        check_eq({tag, "_rdata"}, bus_if.res_data, 0);
        check_eq({tag, "_rerr"}, bus_if.res_err, 0);
        check_eq({tag, "_busy"}, bus_if.busy, 0);
        check_eq({tag, "_cstart"}, bus_if.core_start, 0);
        check_eq({tag, "_cdec"}, bus_if.core_decrypt, 0);
        check_eq({tag, "_ctext"}, bus_if.core_text, 0);
        check_eq({tag, "_ckey"}, bus_if.core_key, 0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic new_data(input bit which);
        if (which) begin
            bus_if.mode1 = 1'($urandom_range(0, 1));
            bus_if.text1 = rnd64();
            bus_if.key1  = rnd64();
        end else begin
            bus_if.mode0 = 1'($urandom_range(0, 1));
            bus_if.text0 = rnd64();
            bus_if.key0  = rnd64();
        end
    endtask

    // Called at a negedge with the arbiter idle and at least one req set up.
    // dly: core_done is sampled dly cycles after the START edge.
    task automatic run_job(input int dly, input bit spurious, input bit drop);
        bit          win;
        bit          exp_mode;
        bit          exp_err;
        int          eff;
        logic [63:0] exp_text, exp_key, result, exp_data;

        win      = (bus_if.req0 && bus_if.req1) ? ~last_m : bus_if.req1;
        exp_mode = win ? bus_if.mode1 : bus_if.mode0;
        exp_text = win ? bus_if.text1 : bus_if.text0;
        exp_key  = win ? bus_if.key1  : bus_if.key0;
        result   = rnd64();
        eff      = dly;
        exp_err  = 1'b0;
`ifdef DES_WDOG_EN
        if (dly > TIMEOUT + 1) begin
            eff     = TIMEOUT + 1;
            exp_err = 1'b1;
        end
`endif
        exp_data = exp_err ? 64'd0 : result;

        @(posedge clk);
        @(negedge clk);
        check_eq("ack_win", win ? bus_if.ack1 : bus_if.ack0, 1);
        check_eq("ack_other", win ? bus_if.ack0 : bus_if.ack1, 0);
        check_eq("start", bus_if.core_start, 1);
        check_eq("busy_start", bus_if.busy, 1);
        check_eq("core_text", bus_if.core_text, exp_text);
        check_eq("core_key", bus_if.core_key, exp_key);
        check_eq("core_dec", bus_if.core_decrypt, exp_mode);

        // The winner's inputs move after ack; the running job must not notice.
        new_data(win);
        if (drop) begin
            if (win) bus_if.req1 = 1'b0;
            else     bus_if.req0 = 1'b0;
        end
        bus_if.core_done   = spurious;
        bus_if.core_result = ~result;

        for (int i = 1; i <= eff; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("wait_ack", {bus_if.ack0, bus_if.ack1}, 0);
            check_eq("wait_start", bus_if.core_start, 0);
            check_eq("wait_rv", {bus_if.res_valid0, bus_if.res_valid1}, 0);
            check_eq("wait_busy", bus_if.busy, 1);
            check_eq("wait_text", bus_if.core_text, exp_text);
            check_eq("wait_dec", bus_if.core_decrypt, exp_mode);
            bus_if.core_done   = (i == eff) && !exp_err;
            bus_if.core_result = result;
        end

        @(posedge clk);
        @(negedge clk);
        bus_if.core_done   = 1'b0;
        bus_if.core_result = rnd64();
        check_eq("rv_win", win ? bus_if.res_valid1 : bus_if.res_valid0, 1);
        check_eq("rv_other", win ? bus_if.res_valid0 : bus_if.res_valid1, 0);
        check_eq("res_data", bus_if.res_data, exp_data);
        check_eq("res_err", bus_if.res_err, exp_err);
        check_eq("resp_busy", bus_if.busy, 1);
        check_eq("resp_key", bus_if.core_key, exp_key);
        last_m = win;
        $display("job %0d grant=%0d dly=%0d spur=%0d err=%0d data=%h",
                 job_no, win, dly, spurious, exp_err, bus_if.res_data);
        job_no++;

        @(posedge clk);
        @(negedge clk);
        check_eq("idle_rv", {bus_if.res_valid0, bus_if.res_valid1}, 0);
        check_eq("idle_busy", bus_if.busy, 0);
        check_eq("hold_data", bus_if.res_data, exp_data);
        check_eq("hold_err", bus_if.res_err, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus_if.core_done   = 1'b0;
        bus_if.core_result = '0;
        bus_if.req0        = 1'b1;
        bus_if.req1        = 1'b1;
        new_data(1'b0);
        new_data(1'b1);

        // Reset with both requests high: everything stays zero.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("post_rst_busy", bus_if.busy, 0);
        end

        // Single job, fixed vector, done 16 cycles after start.
        bus_if.req0  = 1'b1;
        bus_if.mode0 = 1'b0;
        bus_if.text0 = 64'h0123456789ABCDEF;
        bus_if.key0  = 64'd1337;
        run_job(16, 1'b0, 1'b1);

        // core_done in IDLE is ignored.
        bus_if.core_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.core_done = 1'b0;
        check_eq("idle_done_busy", bus_if.busy, 0);
        check_eq("idle_done_rv", {bus_if.res_valid0, bus_if.res_valid1}, 0);

        // Reset in the middle of a req1 job.
        bus_if.req1 = 1'b1;
        new_data(1'b1);
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_ack1", bus_if.ack1, 1);
        bus_if.req1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        last_m = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("mid_rst_rv", {bus_if.res_valid0, bus_if.res_valid1}, 0);
            check_eq("mid_rst_busy", bus_if.busy, 0);
        end

        // Contention: both held, alternation starts with req0.
        bus_if.req0  = 1'b1;
        bus_if.req1  = 1'b1;
        new_data(1'b0);
        new_data(1'b1);
        bus_if.mode0 = 1'b0;
        bus_if.mode1 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            run_job(j + 1, 1'b1, 1'b0);
        end

        // Randomized jobs; a pending (high) request is never dropped before its ack.
        for (int j = 0; j < 40; j++) begin
            if (!bus_if.req0 && !bus_if.req1 && $urandom_range(0, 2) == 0) begin
                bus_if.core_done = 1'b1;
                @(posedge clk);
                @(negedge clk);
                bus_if.core_done = 1'b0;
                check_eq("rnd_idle_busy", bus_if.busy, 0);
                check_eq("rnd_idle_rv", {bus_if.res_valid0, bus_if.res_valid1}, 0);
            end
            if (!bus_if.req0 && $urandom_range(0, 1) == 1) begin
                bus_if.req0 = 1'b1;
                new_data(1'b0);
            end
            if (!bus_if.req1 && $urandom_range(0, 1) == 1) begin
                bus_if.req1 = 1'b1;
                new_data(1'b1);
            end
            if (!bus_if.req0 && !bus_if.req1) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus_if.req1 = 1'b1;
                    new_data(1'b1);
                end else begin
                    bus_if.req0 = 1'b1;
                    new_data(1'b0);
                end
            end
            run_job($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Requests withdrawn before being sampled are not served.
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("withdrawn_busy", bus_if.busy, 0);
            check_eq("withdrawn_ack", {bus_if.ack0, bus_if.ack1}, 0);
        end

`ifdef DES_WDOG_EN
        // Core never answers, then answers exactly at the timeout count.
        bus_if.req0 = 1'b1;
        new_data(1'b0);
        run_job(TIMEOUT + 10, 1'b0, 1'b1);
        bus_if.req0 = 1'b1;
        new_data(1'b0);
        run_job(TIMEOUT + 1, 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
